top_level_spi_slave: RTL and testbench

Memory-mapped SPI slave (mode 0: CPOL=0, CPHA=0, MSB first, 16-bit words) that answers an external SPI master. It pairs with the SPI master already on the bus: same Avalon-style register map, status/control bit positions and IRQ scheme, so the same driver code serves both ends. SCLK, SS_n and MOSI are asynchronous to clk; they are synchronized and edge-detected, and all logic runs on clk.

---
 rtl/top_level_spi_pkg.sv | 25 ++
 rtl/top_level_spi_sync.sv | 41 ++++
 rtl/top_level_spi_slave.sv | 169 ++++++++++++++++
 tb/tb_top_level_spi_slave.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/top_level_spi_pkg.sv
// top_level_spi_pkg
// Shared constants for the memory-mapped SPI slave: register addresses,
// status/control bit positions (identical to the SPI master so one driver
// serves both ends) and the default word width.
`timescale 1ns/1ps
package top_level_spi_pkg;

  localparam int DATABITS_DEFAULT = 16;

  // Register map
  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  // Status bit positions; the control register uses the same positions
  // for the matching interrupt enables.
  localparam int ROE  = 3;
  localparam int TOE  = 4;
  localparam int TUR  = 5;
  localparam int TRDY = 6;
  localparam int RRDY = 7;
  localparam int E    = 8;

endpackage

// File: rtl/top_level_spi_sync.sv
// top_level_spi_sync
// Multi-stage synchronizer for one asynchronous SPI pin, with registered
// single-cycle rise/fall pulses derived from the synchronized level.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   din            asynchronous pin
//   level          synchronized level (resets to IDLE)
//   rise, fall     one-cycle pulses, one clk after the level changes
`timescale 1ns/1ps
module top_level_spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE        = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {SYNC_STAGES{IDLE}};
      prev  <= IDLE;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

  assign level = chain[SYNC_STAGES-1];

endmodule

// File: rtl/top_level_spi_slave.sv
// top_level_spi_slave
// Memory-mapped SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first.
// Ports:
//   clk, reset_n                system clock, asynchronous active-low reset
//   spi_select, mem_addr,
//   read_n, write_n,
//   data_from_cpu, data_to_cpu  Avalon-style register port (2-cycle accesses)
//   irq                         OR of enabled status bits
//   SCLK, SS_n, MOSI            asynchronous pins from the SPI master
//   MISO                        serial output, 0 while not selected
`timescale 1ns/1ps
module top_level_spi_slave
  import top_level_spi_pkg::*;
#(
  parameter int DATABITS    = DATABITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                spi_select,
  input  logic [2:0]          mem_addr,
  input  logic                read_n,
  input  logic                write_n,
  input  logic [DATABITS-1:0] data_from_cpu,
  output logic [DATABITS-1:0] data_to_cpu,
  output logic                irq,
  input  logic                SCLK,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO
);

  localparam int CNT_W = $clog2(DATABITS);
  localparam logic [DATABITS-1:0] CTRL_MASK = DATABITS'(9'h1F8);

  // Pin synchronizers
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  top_level_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .din(SCLK),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));
  top_level_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .din(SS_n),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall));
  top_level_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .din(MOSI),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  // State
  logic [DATABITS-1:0] shift_reg, rx_holding, tx_holding, control;
  logic [CNT_W-1:0]    counter;
  logic                tx_primed, roe, toe, tur, rrdy;
  logic                rd_q, wr_q;

  // Bus strobes: one cycle at the start of each 2-cycle access
  logic rd_strobe, wr_strobe, rd_rx, wr_tx, wr_status, wr_ctrl;
  assign rd_strobe = ~rd_q & spi_select & ~read_n;
  assign wr_strobe = ~wr_q & spi_select & ~write_n;
  assign rd_rx     = rd_strobe & (mem_addr == ADDR_RXDATA);
  assign wr_tx     = wr_strobe & (mem_addr == ADDR_TXDATA);
  assign wr_status = wr_strobe & (mem_addr == ADDR_STATUS);
  assign wr_ctrl   = wr_strobe & (mem_addr == ADDR_CONTROL);

  // Serial events; frame start takes priority over any coincident SCLK edge
  logic ss_active, bit_rise, bit_fall, word_done, load, tx_accept;
  logic [DATABITS-1:0] load_word;
  assign ss_active = ~ss_level;
  assign bit_rise  = ss_active & sclk_rise & ~ss_fall;
  assign bit_fall  = ss_active & sclk_fall & ~ss_fall;
  assign word_done = bit_rise & (counter == CNT_W'(DATABITS-1));
  // A falling edge at counter 0 starts the next word of a streamed transfer
  assign load      = ss_fall | (bit_fall & (counter == '0));
  assign load_word = tx_primed ? tx_holding : '0;
  // A write may refill the holding register in the same cycle a load empties it
  assign tx_accept = wr_tx & (~tx_primed | load);

  logic [DATABITS-1:0] status, read_mux;
  always_comb begin
    status       = '0;
    status[ROE]  = roe;
    status[TOE]  = toe;
    status[TUR]  = tur;
    status[TRDY] = ~tx_primed;
    status[RRDY] = rrdy;
    status[E]    = roe | toe | tur;
  end

  always_comb begin
    read_mux = '0;
    case (mem_addr)
      ADDR_RXDATA:  read_mux = rx_holding;
      ADDR_STATUS:  read_mux = status;
      ADDR_CONTROL: read_mux = control;
      default:      read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg   <= '0;
      rx_holding  <= '0;
      tx_holding  <= '0;
      control     <= '0;
      counter     <= '0;
      tx_primed   <= 1'b0;
      roe         <= 1'b0;
      toe         <= 1'b0;
      tur         <= 1'b0;
      rrdy        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      data_to_cpu <= '0;
      irq         <= 1'b0;
      MISO        <= 1'b0;
    end else begin
      rd_q        <= spi_select & ~read_n;
      wr_q        <= spi_select & ~write_n;
      data_to_cpu <= read_mux;
      irq         <= |(status & control);

      // Bit counter; a frame abort simply forgets the partial word
      if (ss_fall || ss_rise)
        counter <= '0;
      else if (bit_rise)
        counter <= word_done ? '0 : counter + 1'b1;

      // Shared tx/rx shift register: MOSI enters at the bottom on each rise
      if (load)
        shift_reg <= load_word;
      else if (bit_rise)
        shift_reg <= {shift_reg[DATABITS-2:0], mosi_level};

      // MISO advances on loads and falling edges so it is stable at the
      // master's sampling (rising) edge
      if (!ss_active)
        MISO <= 1'b0;
      else if (load)
        MISO <= load_word[DATABITS-1];
      else if (bit_fall)
        MISO <= shift_reg[DATABITS-1];

      if (word_done)
        rx_holding <= {shift_reg[DATABITS-2:0], mosi_level};

      // Transmit holding register
      if (tx_accept) begin
        tx_holding <= data_from_cpu;
        tx_primed  <= 1'b1;
      end else if (load && tx_primed) begin
        tx_primed  <= 1'b0;
      end

      // Flags: a same-cycle event wins over clearing
      if (word_done)
        rrdy <= 1'b1;
      else if (rd_rx || wr_status)
        rrdy <= 1'b0;
      roe <= (roe & ~wr_status) | (word_done & rrdy & ~rd_rx);
      toe <= (toe & ~wr_status) | (wr_tx & ~tx_accept);
      tur <= (tur & ~wr_status) | (load & ~tx_primed);

      if (wr_ctrl)
        control <= data_from_cpu & CTRL_MASK;
    end
  end

endmodule

// File: tb/tb_top_level_spi_slave.sv
// tb_top_level_spi_slave
// Directed bench: bus accesses and SPI frames are issued from one process,
// expected values are queued, and a monitor on the opposite clock edge pops
// and compares whenever read data or a finished MISO word is presented.
`timescale 1ns/1ps
module tb_top_level_spi_slave;
  import top_level_spi_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_select = 1'b0;
  logic [2:0]  mem_addr = '0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [15:0] data_from_cpu = '0;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        SCLK = 1'b0;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;

  top_level_spi_slave #(.DATABITS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .SCLK(SCLK), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(MISO));

  always #5 clk = ~clk;

  // Scoreboard queues
  logic [31:0] exp_rd_q[$];
  string       rd_name_q[$];
  logic [31:0] exp_miso_q[$];
  logic [31:0] obs_miso_q[$];
  string       miso_name_q[$];
  logic [31:0] probe_act_q[$];
  logic [31:0] probe_exp_q[$];
  string       probe_name_q[$];

  int vectors = 0;
  int miscompares = 0;
  int rd_cnt = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: read data is valid in the 2nd cycle of a read access
  initial begin
    forever begin
      @(negedge clk);
      if (!read_n && spi_select) begin
        if (rd_cnt == 1) begin
          if (exp_rd_q.size() == 0)
            compare("rd_unexpected", 32'(data_to_cpu), 32'hFFFF_FFFF);
          else
            compare(rd_name_q.pop_front(), 32'(data_to_cpu), exp_rd_q.pop_front());
        end
        rd_cnt = rd_cnt + 1;
      end else begin
        rd_cnt = 0;
      end
      while (obs_miso_q.size() > 0 && exp_miso_q.size() > 0)
        compare(miso_name_q.pop_front(), obs_miso_q.pop_front(), exp_miso_q.pop_front());
      while (probe_exp_q.size() > 0)
        compare(probe_name_q.pop_front(), probe_act_q.pop_front(), probe_exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic probe(input string name, input logic [31:0] act, input logic [31:0] exp);
    probe_name_q.push_back(name);
    probe_act_q.push_back(act);
    probe_exp_q.push_back(exp);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    spi_select = 1'b1; mem_addr = a; data_from_cpu = d; write_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    write_n = 1'b1; spi_select = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [15:0] exp, input string name);
    exp_rd_q.push_back(32'(exp));
    rd_name_q.push_back(name);
    @(posedge clk); #1;
    spi_select = 1'b1; mem_addr = a; read_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    read_n = 1'b1; spi_select = 1'b0;
  endtask

  // Mode-0 master at clk/16. MISO is sampled just before each rising edge.
  // A completed frame releases SS_n before SCLK returns low.
  task automatic spi_frame(input int nbits, input logic [31:0] mosi_word,
                           input bit end_frame, input bit mid_wr,
                           input logic [15:0] mid_data, input bit chk,
                           input logic [31:0] exp_miso, input string name);
    logic [31:0] got;
    got = '0;
    if (chk) begin
      exp_miso_q.push_back(exp_miso);
      miso_name_q.push_back(name);
    end
    SS_n = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_word[nbits-1-i];
      tick(8);
      got = {got[30:0], MISO};
      SCLK = 1'b1;
      tick(8);
      if (i == nbits - 1 && end_frame) begin
        SS_n = 1'b1;
        tick(8);
      end
      SCLK = 1'b0;
      if (mid_wr && i == 2) bus_write(ADDR_TXDATA, mid_data);
    end
    tick(8);
    if (chk) obs_miso_q.push_back(got);
  endtask

  initial begin
    // Reset state
    tick(4);
    probe("rst_miso", 32'(MISO), 32'h0);
    probe("rst_irq", 32'(irq), 32'h0);
    probe("rst_data_to_cpu", 32'(data_to_cpu), 32'h0);
    reset_n = 1'b1;
    tick(4);
    bus_read(ADDR_STATUS, 16'h0040, "rst_status");
    bus_read(ADDR_CONTROL, 16'h0000, "rst_control");
    bus_read(ADDR_RXDATA, 16'h0000, "rst_rx");

    // 1: basic frame
    bus_write(ADDR_TXDATA, 16'hA55A);
    bus_read(ADDR_STATUS, 16'h0000, "t1_status_primed");
    spi_frame(16, 32'h1234, 1'b1, 1'b0, 16'h0, 1'b1, 32'hA55A, "t1_miso");
    bus_read(ADDR_STATUS, 16'h00C0, "t1_status");
    bus_read(ADDR_RXDATA, 16'h1234, "t1_rx");
    bus_read(ADDR_STATUS, 16'h0040, "t1_status_after_rd");

    // 2: underrun with interrupt
    bus_write(ADDR_CONTROL, 16'h0020);
    bus_read(ADDR_CONTROL, 16'h0020, "t2_control");
    probe("t2_irq_before", 32'(irq), 32'h0);
    spi_frame(16, 32'h5A5A, 1'b1, 1'b0, 16'h0, 1'b1, 32'h0000, "t2_miso");
    probe("t2_irq_set", 32'(irq), 32'h1);
    bus_read(ADDR_STATUS, 16'h01E0, "t2_status");
    bus_read(ADDR_RXDATA, 16'h5A5A, "t2_rx");
    bus_write(ADDR_STATUS, 16'h0000);
    tick(2);
    probe("t2_irq_clear", 32'(irq), 32'h0);
    bus_read(ADDR_STATUS, 16'h0040, "t2_status_clr");
    bus_write(ADDR_CONTROL, 16'h0000);

    // 3: tx overrun discards second write
    bus_write(ADDR_TXDATA, 16'h1111);
    bus_write(ADDR_TXDATA, 16'h2222);
    bus_read(ADDR_STATUS, 16'h0110, "t3_status_toe");
    spi_frame(16, 32'h0F0F, 1'b1, 1'b0, 16'h0, 1'b1, 32'h1111, "t3_miso");
    bus_read(ADDR_STATUS, 16'h01D0, "t3_status");
    bus_read(ADDR_RXDATA, 16'h0F0F, "t3_rx");
    bus_write(ADDR_STATUS, 16'h0000);
    bus_read(ADDR_STATUS, 16'h0040, "t3_status_clr");

    // 4: two streamed words, rx overrun
    bus_write(ADDR_TXDATA, 16'hCAFE);
    spi_frame(32, 32'h1357_9BDF, 1'b1, 1'b1, 16'h3C3C, 1'b1, 32'hCAFE_3C3C, "t4_miso");
    bus_read(ADDR_STATUS, 16'h01C8, "t4_status");
    bus_read(ADDR_RXDATA, 16'h9BDF, "t4_rx");
    bus_write(ADDR_STATUS, 16'h0000);
    bus_read(ADDR_STATUS, 16'h0040, "t4_status_clr");

    // 5: aborted partial frame, then full frame
    bus_write(ADDR_TXDATA, 16'h0001);
    spi_frame(7, 32'h0055, 1'b1, 1'b0, 16'h0, 1'b0, 32'h0, "t5_partial");
    bus_read(ADDR_STATUS, 16'h0040, "t5_status_partial");
    bus_write(ADDR_TXDATA, 16'h0002);
    spi_frame(16, 32'hBEEF, 1'b1, 1'b0, 16'h0, 1'b1, 32'h0002, "t5_miso");
    bus_read(ADDR_STATUS, 16'h00C0, "t5_status");
    bus_read(ADDR_RXDATA, 16'hBEEF, "t5_rx");
    bus_read(ADDR_STATUS, 16'h0040, "t5_status_after_rd");

    // 6: reset mid-frame
    bus_write(ADDR_CONTROL, 16'h0080);
    bus_write(ADDR_TXDATA, 16'h7777);
    spi_frame(9, 32'h01FF, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0, "t6_partial");
    reset_n = 1'b0;
    SS_n = 1'b1;
    SCLK = 1'b0;
    tick(3);
    probe("t6_rst_miso", 32'(MISO), 32'h0);
    probe("t6_rst_irq", 32'(irq), 32'h0);
    probe("t6_rst_data_to_cpu", 32'(data_to_cpu), 32'h0);
    reset_n = 1'b1;
    tick(4);
    bus_read(ADDR_STATUS, 16'h0040, "t6_status");
    bus_read(ADDR_CONTROL, 16'h0000, "t6_control");
    bus_read(ADDR_RXDATA, 16'h0000, "t6_rx_rst");
    bus_write(ADDR_TXDATA, 16'h4321);
    spi_frame(16, 32'h8765, 1'b1, 1'b0, 16'h0, 1'b1, 32'h4321, "t6_miso");
    bus_read(ADDR_STATUS, 16'h00C0, "t6_status_frame");
    bus_read(ADDR_RXDATA, 16'h8765, "t6_rx");

    tick(4);
    probe("rd_queue_left", 32'(exp_rd_q.size()), 32'h0);
    probe("miso_queue_left", 32'(exp_miso_q.size()), 32'h0);
    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
